// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
//
// Shared definitions for logic that reads back a multiplexed, active-low
// 7-segment display bus:
//   - segment patterns (bit order {a,b,c,d,e,f,g}, 0 = segment lit)
//   - digit codes for the non-numeric glyphs
//   - one-hot-low anode constants
//   - pure helpers: pattern -> code, anode word -> classification
// ----------------------------------------------------------------------------
package ssd_pkg;

    // Segment patterns, active low, {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit codes for the glyphs that are not decimal digits
    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BAD   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Anode enables, active low, one bit per digit position
    localparam logic [3:0] ANODE_D0   = 4'b1110;
    localparam logic [3:0] ANODE_D1   = 4'b1101;
    localparam logic [3:0] ANODE_D2   = 4'b1011;
    localparam logic [3:0] ANODE_D3   = 4'b0111;
    localparam logic [3:0] ANODE_NONE = 4'b1111;

    // Frame assembly states
    typedef enum logic {
        FRAME_EMPTY,
        FRAME_COLLECTING
    } frame_state_t;

    // Classification of an anode word
    typedef struct packed {
        logic       none;   // no digit enabled
        logic       multi;  // two or more digits enabled at once
        logic [1:0] idx;    // enabled digit index when exactly one is low
    } anode_info_t;

    // Map a segment pattern to its digit code; unknown patterns give CODE_BAD.
    function automatic logic [3:0] seg_decode(input logic [6:0] pattern);
        logic [3:0] code;
        // NOTE: every path of a combinational case needs a value (here via the
        // default arm), otherwise synthesis infers a latch to hold the old one.
        case (pattern)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_DASH:  code = CODE_DASH;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_BAD;
        endcase
        return code;
    endfunction

    // Count the low anode bits and report which one is low when unique.
    function automatic anode_info_t anode_decode(input logic [3:0] anode_word);
        anode_info_t info;
        int unsigned lows;
        info = '0;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            if (!anode_word[i]) begin
                lows++;
                info.idx = 2'(i);
            end
        end
        info.none  = (lows == 0);
        info.multi = (lows > 1);
        return info;
    endfunction

    // Single-bit mask for a digit position
    function automatic logic [3:0] digit_bit(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ssd_stable_filter.sv
// ----------------------------------------------------------------------------
// ssd_stable_filter
//
// Synchronizes an asynchronous multi-bit word with a 2-flop chain and emits a
// single accept pulse once the synchronized word has been steady for SETTLE
// consecutive cycles. A held word fires only once; the filter re-arms only
// when the word changes. Also used to debounce push buttons.
//
// Latency: with din steady from edge 0, accept is high in the cycle ending at
// edge 2+SETTLE, so a consumer's registers update on that edge.
//
// Ports:
//   clock    in   system clock
//   reset_n  in   synchronous active-low reset
//   din      in   raw asynchronous word
//   dout     out  current synchronized word (valid with accept)
//   accept   out  one-cycle pulse, dout has been steady for SETTLE cycles
// ----------------------------------------------------------------------------
module ssd_stable_filter #(
    parameter int WIDTH  = 11,
    parameter int SETTLE = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             accept
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] word;    // last synchronized value, for change detect
    logic [CW-1:0]    cnt;     // cycles the word has been unchanged
    logic             armed;   // cleared after firing until the word changes

    // cnt reaches SETTLE-1 on the SETTLE-th steady cycle; firing here keeps the
    // consumer's update on the same edge the word completes its settle time.
    assign accept = armed && (sync2 == word) && (cnt == CW'(SETTLE - 1));
    assign dout   = word;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the sync chain.
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            word  <= '0;
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != word) begin
                word  <= sync2;
                cnt   <= '0;
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end else if (armed) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ssd_scan_capture.sv
// ----------------------------------------------------------------------------
// ssd_scan_capture
//
// Receiving end of a multiplexed 7-segment display bus. Filters the anode and
// segment lines, decodes each accepted pattern to a 4-bit code per anode
// position, and publishes a coherent 4-digit snapshot every time the scan
// wraps back to an index at or below the last one collected. If no digit is
// accepted for TIMEOUT cycles the output is declared stale and blanked.
//
// Ports:
//   clock        in   system clock
//   reset_n      in   synchronous active-low reset
//   anode[3:0]   in   active-low digit enables (1110 = digit0 ... 0111 = digit3)
//   SSD[6:0]     in   active-low segments {a,b,c,d,e,f,g}
//   digits[15:0] out  published snapshot, digit k in bits [4k+3:4k]
//   digit_seen   out  mask of digits driven during the published scan
//   frame_valid  out  one-cycle pulse when digits/digit_seen update
//   seg_err      out  one-cycle pulse, accepted pattern not decodable
//   anode_err    out  one-cycle pulse, accepted anode had 2+ bits low
//   stale        out  level, no digit accepted within TIMEOUT cycles
// ----------------------------------------------------------------------------
module ssd_scan_capture
    import ssd_pkg::*;
#(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  anode,
    input  logic [6:0]  SSD,
    output logic [15:0] digits,
    output logic [3:0]  digit_seen,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        anode_err,
    output logic        stale
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [10:0] stable_word;
    logic        accept;

    ssd_stable_filter #(
        .WIDTH  (11),
        .SETTLE (SETTLE)
    ) u_filter (
        .clock   (clock),
        .reset_n (reset_n),
        .din     ({anode, SSD}),
        .dout    (stable_word),
        .accept  (accept)
    );

    // ------------------------------------------------------------------
    // Decode of the accepted word
    // ------------------------------------------------------------------
    anode_info_t ainfo;
    logic [3:0]  code;
    logic        digit_accept;

    assign ainfo        = anode_decode(stable_word[10:7]);
    assign code         = seg_decode(stable_word[6:0]);
    assign digit_accept = accept && !ainfo.none && !ainfo.multi;

    // ------------------------------------------------------------------
    // Frame assembly, timeout and registered outputs
    // ------------------------------------------------------------------
    frame_state_t state;
    logic [3:0]   work [4];   // working digit codes for the scan in progress
    logic [3:0]   wmask;      // digits written during the scan in progress
    logic [1:0]   last;       // highest index collected in this scan
    logic [TW-1:0] tcnt;      // cycles since the last accepted digit

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= FRAME_EMPTY;
            wmask       <= '0;
            last        <= '0;
            // NOTE: the working array is only four nibbles, so it is reset
            // explicitly; a mid-frame reset must not leak old codes forward.
            for (int k = 0; k < 4; k++) begin
                work[k] <= CODE_BLANK;
            end
            tcnt        <= '0;
            stale       <= 1'b1;
            digits      <= 16'hFFFF;
            digit_seen  <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            anode_err   <= 1'b0;

            if (accept && ainfo.multi) begin
                anode_err <= 1'b1;
            end

            if (digit_accept) begin
                seg_err        <= (code == CODE_BAD);
                work[ainfo.idx] <= code;
                tcnt           <= '0;
                stale          <= 1'b0;

                case (state)
                    FRAME_EMPTY: begin
                        wmask <= digit_bit(ainfo.idx);
                        last  <= ainfo.idx;
                        state <= FRAME_COLLECTING;
                    end
                    FRAME_COLLECTING: begin
                        if (ainfo.idx > last) begin
                            wmask <= wmask | digit_bit(ainfo.idx);
                            last  <= ainfo.idx;
                        end else begin
                            // Scan wrapped: publish the pre-write working set;
                            // this digit's new code starts the next frame.
                            digits      <= {work[3], work[2], work[1], work[0]};
                            digit_seen  <= wmask;
                            frame_valid <= 1'b1;
                            wmask       <= digit_bit(ainfo.idx);
                            last        <= ainfo.idx;
                        end
                    end
                    default: state <= FRAME_EMPTY;
                endcase
            end else if (tcnt != TW'(TIMEOUT)) begin
                // Saturating counter: the stale actions run once, on arrival.
                tcnt <= tcnt + TW'(1);
                if (tcnt == TW'(TIMEOUT - 1)) begin
                    stale      <= 1'b1;
                    digits     <= 16'hFFFF;
                    digit_seen <= '0;
                    state      <= FRAME_EMPTY;
                    wmask      <= '0;
                end
            end
        end
    end

endmodule
